reg_select_sequencer: RTL and testbench

- Parametrised successor to the register select/encode logic in the Mini SRC datapath.
- Decodes the Ra/Rb/Rc fields of IR into registered one-hot register-file in/out strobes.
- Adds a multi-register transfer mode: a state machine walks a register bitmask and issues one strobe per step for block load/store sequences.
- Sits between the control unit and the register file.

---
 rtl/reg_select_sequencer.sv | 92 +++++++++
 tb/tb_reg_select_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: registered Ra/Rb/Rc strobe decode plus a multi-register walk over an IR bitmask
module reg_select_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W = 4,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int MASK_LSB = 0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [31:0]         IR,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                start,
  input  logic                dir_out,
  input  logic                advance,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                base_zero,
  output logic [IDX_W-1:0]    cur_idx,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  state_t state, nxt;
  logic [NUM_REGS-1:0] mask, nmask, low, sel_hot;
  logic [IDX_W-1:0] sel, low_idx;
  logic dir, ndir, any_gr, single, zero_n;
  logic unused_ir;
  assign unused_ir = ^IR;
  // field select with Gra > Grb > Grc priority and single-mode decode
  always_comb begin
    any_gr = Gra | Grb | Grc;
    sel = Gra ? IR[RA_LSB +: IDX_W] : Grb ? IR[RB_LSB +: IDX_W] : Grc ? IR[RC_LSB +: IDX_W] : '0;
    sel_hot = NUM_REGS'(1) << sel;
    single = state == IDLE && !start;
    zero_n = BAout && any_gr && sel == '0;
  end
  // next state: latch mask on start, retire the lowest set bit on each advance
  always_comb begin
    nxt = state;
    nmask = mask;
    ndir = dir;
    case (state)
      IDLE: if (start) begin
        nmask = IR[MASK_LSB +: NUM_REGS];
        ndir = dir_out;
        nxt = |nmask ? WALK : DONE;
      end
      WALK: if (advance) begin
        nmask = mask & (mask - NUM_REGS'(1));
        nxt = |nmask ? WALK : DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  // lowest set bit of the upcoming mask, as one-hot and as index
  always_comb begin
    low = nmask & (~nmask + NUM_REGS'(1));
    low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (nmask[i]) low_idx = IDX_W'(i);
  end
  // state and registered outputs; outputs reflect the state being entered
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      mask <= '0;
      dir <= 1'b0;
      reg_in <= '0;
      reg_out <= '0;
      base_zero <= 1'b0;
      cur_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      mask <= nmask;
      dir <= ndir;
      reg_in <= single ? (Rin && any_gr ? sel_hot : '0) : (nxt == WALK && !ndir ? low : '0);
      reg_out <= single ? ((Rout || BAout) && any_gr && !zero_n ? sel_hot : '0) : (nxt == WALK && ndir ? low : '0);
      base_zero <= single && zero_n;
      cur_idx <= single ? sel : nxt == WALK ? low_idx : '0;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_reg_select_sequencer.sv
// tb_reg_select_sequencer: directed and random checks against a queue-based model of the sequencer
module tb_reg_select_sequencer;
  logic clk = 1'b0;
  logic clr, Gra, Grb, Grc, Rin, Rout, BAout, start, dir_out, advance;
  logic [31:0] IR;
  logic [15:0] reg_in, reg_out;
  logic base_zero, busy, done;
  logic [3:0] cur_idx;
  int n_checks = 0;
  int n_fail = 0;
  int mode = 0;
  int q[$];
  bit mdir;
  logic [15:0] e_in, e_out;
  logic e_bz, e_busy, e_done;
  logic [3:0] e_idx;
  bit e_idx_valid;

  reg_select_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .start(start), .dir_out(dir_out),
    .advance(advance), .reg_in(reg_in), .reg_out(reg_out), .base_zero(base_zero),
    .cur_idx(cur_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit single;
    logic [3:0] sel;
    bit any, zero;
    single = 0;
    if (clr) begin
      q.delete();
      mode = 0;
    end else if (mode == 0) begin
      if (start) begin
        q.delete();
        mdir = dir_out;
        for (int i = 0; i < 16; i++) if (IR[i]) q.push_back(i);
        mode = q.size() != 0 ? 1 : 2;
      end else begin
        single = 1;
        any = Gra || Grb || Grc;
        sel = Gra ? IR[23 +: 4] : Grb ? IR[19 +: 4] : Grc ? IR[15 +: 4] : 4'd0;
        zero = BAout && any && sel == 0;
        e_in = (Rin && any) ? 16'(1) << sel : 16'h0;
        e_out = ((Rout || BAout) && any && !zero) ? 16'(1) << sel : 16'h0;
        e_bz = zero;
        e_idx = sel;
        e_idx_valid = any;
        e_busy = 0;
        e_done = 0;
      end
    end else if (mode == 1) begin
      if (advance) begin
        void'(q.pop_front());
        if (q.size() == 0) mode = 2;
      end
    end else mode = 0;
    if (!single) begin
      e_in = (mode == 1 && !mdir) ? 16'(1) << q[0] : 16'h0;
      e_out = (mode == 1 && mdir) ? 16'(1) << q[0] : 16'h0;
      e_bz = 0;
      e_busy = mode != 0;
      e_done = mode == 2;
      e_idx = mode == 1 ? 4'(q[0]) : 4'd0;
      e_idx_valid = mode == 1 || clr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("reg_in", 32'(reg_in), 32'(e_in));
    chk("reg_out", 32'(reg_out), 32'(e_out));
    chk("base_zero", 32'(base_zero), 32'(e_bz));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (e_idx_valid) chk("cur_idx", 32'(cur_idx), 32'(e_idx));
  endtask

  task automatic idle_inputs();
    {Gra, Grb, Grc, Rin, Rout, BAout, start, dir_out, advance} = '0;
  endtask

  initial begin
    clr = 1;
    IR = $urandom;
    {Gra, Grb, Grc, Rin, Rout, BAout, start, dir_out, advance} = 9'($urandom);
    tick();
    IR = $urandom;
    {Gra, Grb, Grc, Rin, Rout, BAout, start, dir_out, advance} = 9'($urandom);
    tick();
    chk("reset_outs", {reg_in, reg_out}, 32'h0);
    chk("reset_flags", {28'h0, base_zero, busy, done, |cur_idx}, 32'h0);
    clr = 0;
    idle_inputs();
    IR = 32'h0298_0000;
    Gra = 1; Rin = 1;
    tick();
    chk("ra_rin", 32'(reg_in), 32'h0020);
    chk("ra_idx", 32'(cur_idx), 32'd5);
    idle_inputs();
    Grb = 1; Rout = 1;
    tick();
    chk("rb_rout", 32'(reg_out), 32'h0008);
    idle_inputs();
    IR = 32'h0000_0000;
    Gra = 1; BAout = 1;
    tick();
    chk("ba_r0_out", 32'(reg_out), 32'h0);
    chk("ba_r0_zero", 32'(base_zero), 32'h1);
    IR = 32'h0200_0000;
    tick();
    chk("ba_r4_out", 32'(reg_out), 32'h0010);
    chk("ba_r4_zero", 32'(base_zero), 32'h0);
    idle_inputs();
    IR = 32'h0000_8025;
    dir_out = 1; start = 1;
    tick();
    chk("walk_out0", 32'(reg_out), 32'h0001);
    start = 0; advance = 1;
    tick();
    chk("walk_out1", 32'(reg_out), 32'h0004);
    tick();
    chk("walk_out2", 32'(reg_out), 32'h0020);
    tick();
    chk("walk_out3", 32'(reg_out), 32'h8000);
    tick();
    chk("walk_done", {30'h0, done, busy}, 32'h3);
    tick();
    chk("walk_idle", {30'h0, done, busy}, 32'h0);
    idle_inputs();
    start = 1;
    tick();
    chk("stall_in0", 32'(reg_in), 32'h0001);
    start = 0;
    tick();
    tick();
    chk("stall_in2", 32'(reg_in), 32'h0001);
    IR = 32'h0000_0F00;
    start = 1; Gra = 1; Rin = 1; BAout = 1;
    tick();
    chk("restart_ign", 32'(reg_in), 32'h0001);
    idle_inputs();
    advance = 1;
    tick();
    chk("resume_in1", 32'(reg_in), 32'h0004);
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    IR = 32'h0298_0000;
    start = 1;
    tick();
    chk("empty_done", {30'h0, done, |reg_in | |reg_out}, 32'h2);
    start = 0;
    tick();
    chk("empty_idle", {30'h0, done, busy}, 32'h0);
    IR = 32'h0000_00F0;
    start = 1;
    tick();
    start = 0;
    clr = 1;
    tick();
    chk("clr_walk", {reg_in, reg_out}, 32'h0);
    clr = 0;
    tick();
    chk("clr_done", {30'h0, done, busy}, 32'h0);
    for (int i = 0; i < 400; i++) begin
      IR = $urandom;
      if ($urandom_range(0, 1) == 1) IR[15:0] = IR[15:0] & 16'($urandom);
      {Gra, Grb, Grc, Rin, Rout, BAout, dir_out} = 7'($urandom);
      start = $urandom_range(0, 5) == 0;
      advance = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 60) == 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
